// File: rtl/spi_regs_pkg.sv
// Shared constants, FSM state type and helpers for the SPI register controller.
package spi_regs_pkg;

  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned CNT_W      = 5;
  localparam int unsigned CNT_SAT    = 17;
  localparam int unsigned ADDR_W     = 7;

  localparam logic [ADDR_W-1:0] ADDR_LED_LO  = 7'h00;
  localparam logic [ADDR_W-1:0] ADDR_LED_HI  = 7'h01;
  localparam logic [ADDR_W-1:0] ADDR_POUT0   = 7'h02;
  localparam logic [ADDR_W-1:0] ADDR_POUT1   = 7'h03;
  localparam logic [ADDR_W-1:0] ADDR_POUT2   = 7'h04;
  localparam logic [ADDR_W-1:0] ADDR_POE0    = 7'h05;
  localparam logic [ADDR_W-1:0] ADDR_POE1    = 7'h06;
  localparam logic [ADDR_W-1:0] ADDR_POE2    = 7'h07;
  localparam logic [ADDR_W-1:0] ADDR_WDIV_LO = 7'h08;
  localparam logic [ADDR_W-1:0] ADDR_WDIV_HI = 7'h09;
  localparam logic [ADDR_W-1:0] ADDR_CTRL    = 7'h0A;
  localparam logic [ADDR_W-1:0] ADDR_PIN0    = 7'h0B;
  localparam logic [ADDR_W-1:0] ADDR_PIN1    = 7'h0C;
  localparam logic [ADDR_W-1:0] ADDR_PIN2    = 7'h0D;
  localparam logic [ADDR_W-1:0] ADDR_STATUS  = 7'h0E;
  localparam logic [ADDR_W-1:0] ADDR_ID      = 7'h7F;

  localparam logic [7:0]  ID_VALUE     = 8'hA5;
  localparam logic [7:0]  MISO_HDR     = 8'h5A;
  localparam logic [15:0] WAVE_DIV_RST = 16'h0001;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  // A divider of zero would stall the waveform generator; clamp it to one.
  function automatic logic [15:0] wave_div_fix(input logic [15:0] v);
    return (v == 16'h0000) ? 16'h0001 : v;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous input with registered edge pulses.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic s1_q, s2_q, rise_q, fall_q;

  // Edge pulses line up with the cycle in which q_o takes its new value.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= RST_VAL;
      s2_q   <= RST_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= d_i;
      s2_q   <= s1_q;
      rise_q <= s1_q & ~s2_q;
      fall_q <= ~s1_q & s2_q;
    end
  end

  assign q_o    = s2_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/spi_reg_ctrl.sv
// SPI mode-0 slave decoding 16-bit frames into a small configuration register file.
module spi_reg_ctrl
  import spi_regs_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        sck,
  input  logic        cs_n,
  input  logic        mosi,
  output logic        miso,
  input  logic [23:0] pin_in,
  output logic [15:0] led_data,
  output logic [23:0] pin_out,
  output logic [23:0] pin_oe,
  output logic [15:0] wave_div,
  output logic [1:0]  wave_mode,
  output logic        pdm_en,
  output logic        cfg_strobe,
  output logic        frame_err
);

  logic sck_s, sck_rise, sck_fall;
  logic cs_s, cs_rise, cs_fall;
  logic mosi_s, mosi_rise, mosi_fall;

  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sck (
    .clk(clk), .rst(rst), .d_i(sck), .q_o(sck_s), .rise_o(sck_rise), .fall_o(sck_fall)
  );
  // cs_n resets to the "selected" level so a frame in flight across reset is not re-entered.
  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_cs (
    .clk(clk), .rst(rst), .d_i(cs_n), .q_o(cs_s), .rise_o(cs_rise), .fall_o(cs_fall)
  );
  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .d_i(mosi), .q_o(mosi_s), .rise_o(mosi_rise), .fall_o(mosi_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{sck_s, cs_s, mosi_rise, mosi_fall};

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [FRAME_BITS-1:0] shin_q, shin_d;
  logic [FRAME_BITS-1:0] shout_q, shout_d;
  logic [7:0]            rdbuf_q, rdbuf_d;
  logic [15:0]           led_q, led_d;
  logic [23:0]           pout_q, pout_d;
  logic [23:0]           poe_q, poe_d;
  logic [15:0]           wdiv_q, wdiv_d;
  logic [1:0]            wmode_q, wmode_d;
  logic                  pdm_q, pdm_d;
  logic                  strobe_q, strobe_d;
  logic                  ferr_q, ferr_d;
  logic                  miso_q, miso_d;

  logic [ADDR_W-1:0]     fr_addr;
  logic [7:0]            fr_data;
  logic [7:0]            rd_val;

  assign fr_addr = shin_q[14:8];
  assign fr_data = shin_q[7:0];

  // Read-back value for the address held in the completed frame.
  always_comb begin
    rd_val = 8'h00;
    case (fr_addr)
      ADDR_LED_LO:  rd_val = led_q[7:0];
      ADDR_LED_HI:  rd_val = led_q[15:8];
      ADDR_POUT0:   rd_val = pout_q[7:0];
      ADDR_POUT1:   rd_val = pout_q[15:8];
      ADDR_POUT2:   rd_val = pout_q[23:16];
      ADDR_POE0:    rd_val = poe_q[7:0];
      ADDR_POE1:    rd_val = poe_q[15:8];
      ADDR_POE2:    rd_val = poe_q[23:16];
      ADDR_WDIV_LO: rd_val = wdiv_q[7:0];
      ADDR_WDIV_HI: rd_val = wdiv_q[15:8];
      ADDR_CTRL:    rd_val = {5'b0, pdm_q, wmode_q};
      ADDR_PIN0:    rd_val = pin_in[7:0];
      ADDR_PIN1:    rd_val = pin_in[15:8];
      ADDR_PIN2:    rd_val = pin_in[23:16];
      ADDR_STATUS:  rd_val = {ferr_q, 7'b0};
      ADDR_ID:      rd_val = ID_VALUE;
      default:      rd_val = 8'h00;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shin_d   = shin_q;
    shout_d  = shout_q;
    rdbuf_d  = rdbuf_q;
    led_d    = led_q;
    pout_d   = pout_q;
    poe_d    = poe_q;
    wdiv_d   = wdiv_q;
    wmode_d  = wmode_q;
    pdm_d    = pdm_q;
    strobe_d = 1'b0;
    ferr_d   = ferr_q;

    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          shout_d = {MISO_HDR, rdbuf_q};
        end
      end
      ST_SHIFT: begin
        // Same-cycle sck edge is folded in before the frame is handed to COMMIT.
        if (sck_rise) begin
          shin_d = {shin_q[FRAME_BITS-2:0], mosi_s};
          if (cnt_q != CNT_W'(CNT_SAT)) cnt_d = cnt_q + CNT_W'(1);
        end
        if (sck_fall && (cnt_q != '0)) shout_d = {shout_q[FRAME_BITS-2:0], 1'b0};
        if (cs_rise) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
        if (cnt_q != CNT_W'(FRAME_BITS)) begin
          ferr_d = 1'b1;
        end else if (!shin_q[15]) begin
          rdbuf_d = rd_val;
        end else begin
          strobe_d = 1'b1;
          case (fr_addr)
            ADDR_LED_LO:  led_d[7:0]    = fr_data;
            ADDR_LED_HI:  led_d[15:8]   = fr_data;
            ADDR_POUT0:   pout_d[7:0]   = fr_data;
            ADDR_POUT1:   pout_d[15:8]  = fr_data;
            ADDR_POUT2:   pout_d[23:16] = fr_data;
            ADDR_POE0:    poe_d[7:0]    = fr_data;
            ADDR_POE1:    poe_d[15:8]   = fr_data;
            ADDR_POE2:    poe_d[23:16]  = fr_data;
            ADDR_WDIV_LO: wdiv_d = wave_div_fix({wdiv_q[15:8], fr_data});
            ADDR_WDIV_HI: wdiv_d = wave_div_fix({fr_data, wdiv_q[7:0]});
            ADDR_CTRL: begin
              pdm_d   = fr_data[2];
              wmode_d = fr_data[1:0];
            end
            ADDR_STATUS:  if (fr_data[7]) ferr_d = 1'b0;
            default:      strobe_d = 1'b0;
          endcase
        end
      end
      default: state_d = ST_IDLE;
    endcase

    miso_d = (state_d == ST_SHIFT) ? shout_d[FRAME_BITS-1] : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      shin_q   <= '0;
      shout_q  <= '0;
      rdbuf_q  <= 8'h00;
      led_q    <= '0;
      pout_q   <= '0;
      poe_q    <= '0;
      wdiv_q   <= WAVE_DIV_RST;
      wmode_q  <= '0;
      pdm_q    <= 1'b0;
      strobe_q <= 1'b0;
      ferr_q   <= 1'b0;
      miso_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shin_q   <= shin_d;
      shout_q  <= shout_d;
      rdbuf_q  <= rdbuf_d;
      led_q    <= led_d;
      pout_q   <= pout_d;
      poe_q    <= poe_d;
      wdiv_q   <= wdiv_d;
      wmode_q  <= wmode_d;
      pdm_q    <= pdm_d;
      strobe_q <= strobe_d;
      ferr_q   <= ferr_d;
      miso_q   <= miso_d;
    end
  end

  assign miso       = miso_q;
  assign led_data   = led_q;
  assign pin_out    = pout_q;
  assign pin_oe     = poe_q;
  assign wave_div   = wdiv_q;
  assign wave_mode  = wmode_q;
  assign pdm_en     = pdm_q;
  assign cfg_strobe = strobe_q;
  assign frame_err  = ferr_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Randomized bench for spi_reg_ctrl against a frame-level register model.
module tb_spi_reg_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sck = 1'b0;
  logic        cs_n = 1'b1;
  logic        mosi = 1'b0;
  logic [23:0] pin_in = 24'h000000;
  logic        miso;
  logic [15:0] led_data;
  logic [23:0] pin_out;
  logic [23:0] pin_oe;
  logic [15:0] wave_div;
  logic [1:0]  wave_mode;
  logic        pdm_en;
  logic        cfg_strobe;
  logic        frame_err;

  always #5 clk = ~clk;

  spi_reg_ctrl dut (
    .clk(clk), .rst(rst), .sck(sck), .cs_n(cs_n), .mosi(mosi), .miso(miso),
    .pin_in(pin_in), .led_data(led_data), .pin_out(pin_out), .pin_oe(pin_oe),
    .wave_div(wave_div), .wave_mode(wave_mode), .pdm_en(pdm_en),
    .cfg_strobe(cfg_strobe), .frame_err(frame_err)
  );

  int errors = 0;
  int checks = 0;
  int unsigned cyc = 0;

  // Model: writable bytes 0x00..0x0A, read buffer, sticky error flag.
  logic [7:0]  m_byte [0:10];
  logic [7:0]  m_rdbuf;
  logic        m_ferr;

  // Frame handed from the host driver to the model, applied at a fixed cycle.
  logic        pend_v = 1'b0;
  int unsigned pend_cyc = 0;
  int          pend_n = 0;
  logic [15:0] pend_w = 16'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i <= 10; i++) m_byte[i] = 8'h00;
    m_byte[8] = 8'h01;
    m_rdbuf = 8'h00;
    m_ferr = 1'b0;
  endtask

  function automatic logic [7:0] m_read(input logic [6:0] a, input logic [23:0] pins);
    if (a <= 7'd10) return m_byte[a[3:0]];
    case (a)
      7'h0B:   return pins[7:0];
      7'h0C:   return pins[15:8];
      7'h0D:   return pins[23:16];
      7'h0E:   return {m_ferr, 7'b0};
      7'h7F:   return 8'hA5;
      default: return 8'h00;
    endcase
  endfunction

  task automatic m_commit(input int n, input logic [15:0] w, output logic strobe);
    logic [6:0] a;
    logic [7:0] d;
    strobe = 1'b0;
    a = w[14:8];
    d = w[7:0];
    if (n != 16) begin
      m_ferr = 1'b1;
    end else if (!w[15]) begin
      m_rdbuf = m_read(a, pin_in);
    end else if (a <= 7'd10) begin
      strobe = 1'b1;
      m_byte[a[3:0]] = (a == 7'd10) ? {5'b0, d[2:0]} : d;
      if (m_byte[8] == 8'h00 && m_byte[9] == 8'h00) m_byte[8] = 8'h01;
    end else if (a == 7'h0E) begin
      strobe = 1'b1;
      if (d[7]) m_ferr = 1'b0;
    end
  endtask

  // Cycle-accurate comparison of every registered output against the model.
  initial begin
    logic exp_strobe;
    int   cs_hi;
    cs_hi = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      exp_strobe = 1'b0;
      if (rst) begin
        m_reset();
        pend_v = 1'b0;
        chk("miso_reset", 32'(miso), 32'(1'b0));
      end else if (pend_v && cyc == pend_cyc) begin
        m_commit(pend_n, pend_w, exp_strobe);
        pend_v = 1'b0;
      end
      chk("led_data", 32'(led_data), 32'({m_byte[1], m_byte[0]}));
      chk("pin_out", 32'(pin_out), 32'({m_byte[4], m_byte[3], m_byte[2]}));
      chk("pin_oe", 32'(pin_oe), 32'({m_byte[7], m_byte[6], m_byte[5]}));
      chk("wave_div", 32'(wave_div), 32'({m_byte[9], m_byte[8]}));
      chk("wave_mode", 32'(wave_mode), 32'(m_byte[10][1:0]));
      chk("pdm_en", 32'(pdm_en), 32'(m_byte[10][2]));
      chk("frame_err", 32'(frame_err), 32'(m_ferr));
      chk("cfg_strobe", 32'(cfg_strobe), 32'(exp_strobe));
      cs_hi = cs_n ? cs_hi + 1 : 0;
      if (cs_hi >= 4) chk("miso_idle", 32'(miso), 32'(1'b0));
    end
  end

  // Host side of one frame: n sck pulses, mode 0, sampling miso before each rise.
  task automatic send_frame(input logic [15:0] w, input int n, output logic [15:0] got);
    logic [15:0] exp;
    logic [15:0] sh;
    exp = {8'h5A, m_rdbuf};
    sh = w;
    got = 16'h0;
    @(negedge clk);
    cs_n = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      if (i < 16) begin
        mosi = sh[15];
        sh = {sh[14:0], 1'b0};
      end else begin
        mosi = 1'($urandom);
      end
      repeat (5) @(negedge clk);
      if (i < 16) got = {got[14:0], miso};
      sck = 1'b1;
      repeat (5) @(negedge clk);
      sck = 1'b0;
    end
    repeat (5) @(negedge clk);
    cs_n = 1'b1;
    pend_w = w;
    pend_n = n;
    pend_cyc = cyc + 4;
    pend_v = 1'b1;
    repeat (10) @(negedge clk);
    if (n >= 16) chk("miso_reply", 32'(got), 32'(exp));
  endtask

  // Write frame cut short by reset after 8 bits; the tail is clocked in after reset.
  task automatic reset_mid_frame(input logic [15:0] w);
    logic [15:0] sh;
    sh = w;
    @(negedge clk);
    cs_n = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      if (i == 8) begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
      end
      mosi = sh[15];
      sh = {sh[14:0], 1'b0};
      repeat (5) @(negedge clk);
      sck = 1'b1;
      repeat (5) @(negedge clk);
      sck = 1'b0;
    end
    repeat (5) @(negedge clk);
    cs_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    logic [15:0] got;
    logic [6:0]  a;
    logic [7:0]  d;
    int          n;
    int          r;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("wave_div_reset", 32'(wave_div), 32'(16'h0001));

    // Two byte writes build the LED word.
    send_frame({1'b1, 7'h00, 8'h23}, 16, got);
    send_frame({1'b1, 7'h01, 8'h80}, 16, got);
    chk("led_lit", 32'(led_data), 32'(16'h8023));

    // ID read returned in the following frame.
    send_frame({1'b0, 7'h7F, 8'h00}, 16, got);
    send_frame({1'b0, 7'h30, 8'h00}, 16, got);
    chk("id_reply_lit", 32'(got), 32'(16'h5AA5));

    // Short frame flags an error and leaves registers alone; status write clears it.
    send_frame({1'b1, 7'h00, 8'hFF}, 12, got);
    chk("short_led_lit", 32'(led_data), 32'(16'h8023));
    chk("short_ferr_lit", 32'(frame_err), 32'(1'b1));
    send_frame({1'b1, 7'h0E, 8'h80}, 16, got);
    chk("ferr_clr_lit", 32'(frame_err), 32'(1'b0));

    // Pin snapshots; later pin changes must not alter a pending reply.
    pin_in = 24'hC3B2A1;
    send_frame({1'b0, 7'h0B, 8'h00}, 16, got);
    send_frame({1'b0, 7'h0D, 8'h00}, 16, got);
    chk("pin0_reply_lit", 32'(got), 32'(16'h5AA1));
    pin_in = 24'h123456;
    send_frame({1'b0, 7'h40, 8'h00}, 16, got);
    chk("pin2_reply_lit", 32'(got), 32'(16'h5AC3));

    // Divider clamps to one; CTRL fields.
    send_frame({1'b1, 7'h08, 8'h00}, 16, got);
    send_frame({1'b1, 7'h09, 8'h00}, 16, got);
    chk("wdiv_clamp_lit", 32'(wave_div), 32'(16'h0001));
    send_frame({1'b1, 7'h0A, 8'h05}, 16, got);
    chk("wave_mode_lit", 32'(wave_mode), 32'(2'd1));
    chk("pdm_en_lit", 32'(pdm_en), 32'(1'b1));

    // Reset in the middle of a pin_out write, then a clean frame.
    reset_mid_frame({1'b1, 7'h02, 8'h7E});
    chk("rst_pin_out_lit", 32'(pin_out), 32'(24'h0));
    send_frame({1'b1, 7'h02, 8'h3C}, 16, got);
    chk("post_rst_pin_out_lit", 32'(pin_out), 32'(24'h00003C));

    // Randomized frames across the map, including odd lengths and zero data.
    for (int k = 0; k < 110; k++) begin
      if ($urandom_range(0, 3) == 0) pin_in = 24'($urandom);
      r = int'($urandom_range(0, 9));
      if (r < 7)       a = 7'($urandom_range(0, 15));
      else if (r == 7) a = 7'h7F;
      else             a = 7'($urandom);
      d = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      r = int'($urandom_range(0, 9));
      if (r < 8)       n = 16;
      else if (r == 8) n = int'($urandom_range(4, 15));
      else             n = int'($urandom_range(17, 20));
      send_frame({1'($urandom), a, d}, n, got);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_reg_ctrl.md
SPI_REG_CTRL -- requirements
Module: spi_reg_ctrl

Interface
REQ-001 clk  in  1  system clock, 48 MHz internal oscillator domain.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 sck  in  1  SPI clock from host, asynchronous, at most clk/8.
REQ-004 cs_n  in  1  SPI chip select, active-low, asynchronous.
REQ-005 mosi  in  1  SPI data from host, asynchronous.
REQ-006 miso  out  1  SPI data to host; 0 while cs_n high.
REQ-007 pin_in  in  24  breakout pin levels, readable.
REQ-008 led_data  out  16  4x4 LED matrix bit pattern.
REQ-009 pin_out  out  24  breakout pin output values.
REQ-010 pin_oe  out  24  breakout pin output enables, 1 = drive.
REQ-011 wave_div  out  16  waveform generator clock divider.
REQ-012 wave_mode  out  2  waveform select: 0 off, 1 saw, 2 square, 3 reserved.
REQ-013 pdm_en  out  1  PDM modulator enable.
REQ-014 cfg_strobe  out  1  one-cycle pulse on every committed register write.
REQ-015 frame_err  out  1  sticky flag: a frame ended with a bit count other than 16.

Function
REQ-016 sck, cs_n and mosi SHALL each pass through a 2-flop synchronizer; edges are detected on the synchronized values.
REQ-017 SPI mode 0, MSB first: mosi sampled on sck rising, miso updated on sck falling.
REQ-018 Frame = 16 bits: bit15 W (1 = write), bits14:8 ADDR, bits7:0 DATA.
REQ-019 FSM states: IDLE, SHIFT, COMMIT. IDLE->SHIFT on cs_n fall; SHIFT->COMMIT on cs_n rise; COMMIT->IDLE after one cycle.
REQ-020 On cs_n fall, miso shift register SHALL load {8'h5A, rdbuf}; miso presents bit15 before the first sck rise.
REQ-021 A 5-bit bit counter SHALL saturate at 17; sck edges in IDLE are ignored.
REQ-022 COMMIT with count == 16: a write updates the addressed register; a read loads rdbuf with the addressed value for return in the next frame.
REQ-023 COMMIT with count != 16: frame discarded, frame_err set, rdbuf unchanged.
REQ-024 Register map:
- 0x00/0x01 led_data lo/hi
- 0x02-0x04 pin_out bytes 0-2
- 0x05-0x07 pin_oe bytes 0-2
- 0x08/0x09 wave_div lo/hi
- 0x0A CTRL {5'b0, pdm_en, wave_mode}
- 0x0B-0x0D pin_in bytes 0-2, read-only
- 0x0E STATUS {frame_err, 7'b0}; a write with DATA bit7 = 1 clears frame_err
- 0x7F ID = 8'hA5, read-only
REQ-025 Writes to read-only or unmapped addresses SHALL be ignored without a strobe; reads of unmapped addresses return 8'h00.
REQ-026 A write to wave_div with a resulting value of 0 SHALL store 1.
REQ-027 A register update and cfg_strobe SHALL appear together, exactly 1 clk after COMMIT entry.
REQ-028 pin_in SHALL be snapshotted into rdbuf in the COMMIT cycle; later pin changes do not alter a pending reply.
REQ-029 cs_n rising while an sck edge is being detected: the edge is processed first, then the commit.

Reset
REQ-030 rst SHALL reset the FSM to IDLE, counter 0, and rdbuf 8'h00.
REQ-031 Output reset values: led_data 0, pin_out 0, pin_oe 0, wave_div 16'h0001, wave_mode 0, pdm_en 0, cfg_strobe 0, frame_err 0, miso 0.
REQ-032 rst mid-frame aborts the frame with no register change; shifting resumes only after a fresh cs_n fall.

Structure
REQ-033 Shared package spi_regs_pkg: address constants, ID value 8'hA5, MISO header 8'h5A, FSM state enum, reset value of wave_div.
REQ-034 One sub-module, spi_sync_edge: 2-flop synchronizer with rise/fall pulses, instantiated for sck, cs_n and mosi.

Verification
REQ-035 Write 0x00=0x23, then 0x01=0x80 -> led_data=16'h8023; one cfg_strobe per frame.
REQ-036 Read 0x7F, then any frame -> second frame's miso returns 16'h5AA5.
REQ-037 Send a 12-bit frame to 0x00 -> led_data unchanged, frame_err=1; write 0x0E=0x80 -> frame_err=0.
REQ-038 pin_in=24'hC3B2A1, read 0x0B then 0x0D -> replies 16'h5AA1 then 16'h5AC3.
REQ-039 Write 0x08=0x00 and 0x09=0x00 -> wave_div=16'h0001; write 0x0A=0x05 -> wave_mode=1, pdm_en=1.
REQ-040 Assert rst after 8 bits of a write to 0x02 -> pin_out=0; next full frame is decoded correctly.
